// File: rtl/receber_pkg.sv
// receber_pkg -- shared definitions for the receber serial nibble receiver.
//   state_t      : receiver FSM states
//   DATA_W       : width of each payload nibble (dado / instrucao)
//   PAYLOAD_BITS : number of payload bits per frame
//   FRAME_BITS   : start + payload + stop
//   ERR_W/ERR_MAX: width and saturation value of the frame error counter
package receber_pkg;

    localparam int DATA_W       = 4;
    localparam int PAYLOAD_BITS = 8;
    localparam int FRAME_BITS   = 10;
    localparam int ERR_W        = 8;

    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } state_t;

endpackage

// File: rtl/receber_bit_timer.sv
// bit_timer -- bit-period timing for the receber serial receiver.
//   clock   : rising-edge system clock
//   reset_n : asynchronous reset, active low
//   restart : pulse on the edge a start bit is first seen (time zero)
//   tick    : high on the edge MID cycles after restart, then every
//             BIT_CYCLES cycles after that (MID = (BIT_CYCLES-1)/2)
module bit_timer #(
    parameter int BIT_CYCLES = 1
) (
    input  logic clock,
    input  logic reset_n,
    input  logic restart,
    output logic tick
);

    localparam int MID = (BIT_CYCLES - 1) / 2;
    localparam int CW  = $clog2(BIT_CYCLES + 1);

    localparam logic [CW-1:0] MID_C = CW'(MID);
    localparam logic [CW-1:0] PER_C = CW'(BIT_CYCLES);
    localparam logic [CW-1:0] ONE_C = CW'(1);

    // cnt holds the number of the upcoming edge relative to the last
    // restart or tick; first selects the half-bit (MID) interval.
    logic [CW-1:0] cnt;
    logic          first;

    assign tick = first ? (cnt == MID_C) : (cnt == PER_C);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt   <= '0;
            first <= 1'b0;
        end else if (restart) begin
            cnt   <= ONE_C;
            // With MID = 0 the half-bit point is the restart edge itself,
            // so the first tick already lands one full bit later.
            first <= (MID != 0);
        end else if (tick) begin
            cnt   <= ONE_C;
            first <= 1'b0;
        end else begin
            cnt   <= cnt + ONE_C;
        end
    end

endmodule

// File: rtl/receber.sv
// receber -- serial receiver for 10-bit frames:
//   start(0), dado[0..3], instrucao[0..3] (LSB first), stop(1).
// Ports:
//   clock       : rising-edge system clock
//   reset_n     : asynchronous reset, active low
//   rx          : serial line, idle high, synchronous to clock
//   dado        : data nibble of the last good frame
//   instrucao   : instruction nibble of the last good frame
//   valid       : one-cycle pulse after a frame with a good stop bit
//   frame_error : one-cycle pulse after a frame whose stop bit was low
//   busy        : high whenever the receiver is not idle
//   err_count   : saturating count of frame errors
module receber
    import receber_pkg::*;
#(
    parameter int BIT_CYCLES = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              rx,
    output logic [DATA_W-1:0] dado,
    output logic [DATA_W-1:0] instrucao,
    output logic              valid,
    output logic              frame_error,
    output logic              busy,
    output logic [ERR_W-1:0]  err_count
);

    localparam int MID = (BIT_CYCLES - 1) / 2;
    localparam int BW  = $clog2(PAYLOAD_BITS);

    localparam logic [BW-1:0] LAST_BIT = BW'(PAYLOAD_BITS - 1);

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (v == ERR_MAX) ? v : v + ERR_W'(1);
    endfunction

    state_t                  state, state_nx;
    logic [BW-1:0]           bit_cnt;
    logic [PAYLOAD_BITS-1:0] shreg;
    logic                    tick;
    logic                    restart;
    logic                    shift_en;
    logic                    good;
    logic                    bad;

    bit_timer #(
        .BIT_CYCLES(BIT_CYCLES)
    ) u_timer (
        .clock  (clock),
        .reset_n(reset_n),
        .restart(restart),
        .tick   (tick)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        restart  = 1'b0;
        shift_en = 1'b0;
        good     = 1'b0;
        bad      = 1'b0;
        case (state)
            IDLE: begin
                if (!rx) begin
                    restart  = 1'b1;
                    // With MID = 0 the start re-check coincides with detection.
                    state_nx = (MID == 0) ? DATA : START;
                end
            end
            START: begin
                if (tick) state_nx = rx ? IDLE : DATA;
            end
            DATA: begin
                if (tick) begin
                    shift_en = 1'b1;
                    if (bit_cnt == LAST_BIT) state_nx = STOP;
                end
            end
            STOP: begin
                if (tick) begin
                    if (rx) begin
                        good     = 1'b1;
                        state_nx = IDLE;
                    end else begin
                        bad      = 1'b1;
                        state_nx = WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                if (rx) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bit_cnt     <= '0;
            shreg       <= '0;
            dado        <= '0;
            instrucao   <= '0;
            valid       <= 1'b0;
            frame_error <= 1'b0;
            err_count   <= '0;
        end else begin
            valid       <= good;
            frame_error <= bad;
            if (restart) begin
                bit_cnt <= '0;
            end else if (shift_en) begin
                bit_cnt <= bit_cnt + BW'(1);
            end
            // LSB-first line: each new bit enters at the top, so after eight
            // shifts payload bit 0 sits in shreg[0].
            if (shift_en) shreg <= {rx, shreg[PAYLOAD_BITS-1:1]};
            if (good) begin
                dado      <= shreg[DATA_W-1:0];
                instrucao <= shreg[PAYLOAD_BITS-1:DATA_W];
            end
            if (bad) err_count <= sat_inc(err_count);
        end
    end

endmodule
